// File: rtl/jts16_mapgen_pkg.sv
// Shared definitions for the jts16_mapgen address mapper.
//   - master FSM state encoding
//   - master command codes
//   - register offsets of the master block, relative to M = 2*NREG
//   - size_mask(): region size code to 8-bit compare mask
package jts16_mapgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CYC  = 2'd2,
    ST_DONE = 2'd3
  } mst_state_t;

  localparam logic [1:0] CMD_WR = 2'b01;
  localparam logic [1:0] CMD_RD = 2'b10;

  localparam logic [2:0] OFS_DHI  = 3'd0;
  localparam logic [2:0] OFS_DLO  = 3'd1;
  localparam logic [2:0] OFS_AHI  = 3'd2;
  localparam logic [2:0] OFS_AMID = 3'd3;
  localparam logic [2:0] OFS_ALO  = 3'd4;
  localparam logic [2:0] OFS_CMD  = 3'd5;
  localparam logic [2:0] OFS_STAT = 3'd6;

  // Larger size codes ignore more low bits of the top address byte.
  function automatic logic [7:0] size_mask(input logic [1:0] code);
    case (code)
      2'd0:    return 8'hFF;
      2'd1:    return 8'hFE;
      2'd2:    return 8'hF8;
      default: return 8'hE0;
    endcase
  endfunction

endpackage

// File: rtl/jts16_mapgen_master.sv
// Bus-master engine: performs one 16-bit read or write per command.
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   i_we, i_sel, i_din    register write strobe, master register offset, data
//   i_gnt, i_rdata, i_ack bus grant, read data, acknowledge
//   o_req, o_asn, o_rnw   bus request, address strobe (low active), direction
//   o_wdata, o_addr       write data and address presented to the bus
//   o_dhi..o_alo          data/address registers for read-back
//   o_busy, o_err         engine not idle, sticky timeout flag
module jts16_mapgen_master
  import jts16_mapgen_pkg::*;
#(
  parameter int AW   = 23,
  parameter int TOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_we,
  input  logic [2:0]  i_sel,
  input  logic [7:0]  i_din,
  input  logic        i_gnt,
  input  logic [15:0] i_rdata,
  input  logic        i_ack,
  output logic        o_req,
  output logic        o_asn,
  output logic        o_rnw,
  output logic [15:0] o_wdata,
  output logic [AW:1] o_addr,
  output logic [7:0]  o_dhi,
  output logic [7:0]  o_dlo,
  output logic [7:0]  o_ahi,
  output logic [7:0]  o_amid,
  output logic [7:0]  o_alo,
  output logic        o_busy,
  output logic        o_err
);

  localparam int TW = $clog2(TOUT + 1);
  // Last count value before the timeout fires; the counter never passes it.
  localparam logic [TW-1:0] TLAST = TW'(TOUT - 1);

  mst_state_t    r_state;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_dhi, r_dlo, r_ahi, r_amid, r_alo;
  logic          r_req, r_asn, r_rnw, r_err;
  logic          w_cmd_ok;

  assign w_cmd_ok = i_we && (i_sel == OFS_CMD) && (i_din[1:0] == CMD_WR || i_din[1:0] == CMD_RD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_tcnt  <= '0;
      r_dhi   <= '0;
      r_dlo   <= '0;
      r_ahi   <= '0;
      r_amid  <= '0;
      r_alo   <= '0;
      r_req   <= 1'b0;
      r_asn   <= 1'b1;
      r_rnw   <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      if (i_we) begin
        case (i_sel)
          OFS_DHI:  r_dhi  <= i_din;
          OFS_DLO:  r_dlo  <= i_din;
          OFS_AHI:  r_ahi  <= i_din;
          OFS_AMID: r_amid <= i_din;
          OFS_ALO:  r_alo  <= i_din;
          default: ;
        endcase
      end
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_ok) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_err   <= 1'b0;
            r_rnw   <= (i_din[1:0] == CMD_RD);
          end
        end
        ST_REQ: begin
          if (i_gnt) begin
            r_state <= ST_CYC;
            r_asn   <= 1'b0;
            r_tcnt  <= '0;
          end
        end
        ST_CYC: begin
          if (i_ack) begin
            r_state <= ST_DONE;
            r_asn   <= 1'b1;
            r_req   <= 1'b0;
            // Bus data wins over a same-cycle register write.
            if (r_rnw) {r_dhi, r_dlo} <= i_rdata;
          end else if (r_tcnt == TLAST) begin
            r_state <= ST_DONE;
            r_asn   <= 1'b1;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_rnw   <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req   = r_req;
  assign o_asn   = r_asn;
  assign o_rnw   = r_rnw;
  assign o_wdata = {r_dhi, r_dlo};
  assign o_addr  = AW'({r_ahi, r_amid, r_alo});
  assign o_dhi   = r_dhi;
  assign o_dlo   = r_dlo;
  assign o_ahi   = r_ahi;
  assign o_amid  = r_amid;
  assign o_alo   = r_alo;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_err   = r_err;

endmodule

// File: rtl/jts16_mapgen.sv
// Programmable 68000 address mapper with per-region DTACK waits and a
// single-access bus-master engine.
// Ports:
//   clk, rstn                        clock, asynchronous active-low reset
//   cpu_cen, addr, cpu_asn, cpu_fc   68000 side inputs
//   ext_ack                          acknowledge for external-wait regions
//   cpu_dtackn, active, none         DTACK and region decode outputs
//   reg_we, reg_addr, reg_din        register write port
//   reg_dout                         registered register read data
//   bus_*                            master bus interface, bus_addr shared
//   busy, err                        master status
module jts16_mapgen
  import jts16_mapgen_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = 23,
  parameter int WW   = 2,
  parameter int TOUT = 255,
  localparam int RAW = $clog2(2 * NREG + 8)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cpu_cen,
  input  logic [AW:1]     addr,
  input  logic            cpu_asn,
  input  logic [2:0]      cpu_fc,
  input  logic            ext_ack,
  output logic            cpu_dtackn,
  output logic [NREG-1:0] active,
  output logic            none,
  input  logic            reg_we,
  input  logic [RAW-1:0]  reg_addr,
  input  logic [7:0]      reg_din,
  output logic [7:0]      reg_dout,
  output logic            bus_req,
  input  logic            bus_gnt,
  output logic [AW:1]     bus_addr,
  output logic            bus_asn,
  output logic            bus_rnw,
  output logic [15:0]     bus_din,
  input  logic [15:0]     bus_dout,
  input  logic            bus_ack,
  output logic            busy,
  output logic            err
);

  localparam int M = 2 * NREG;

  logic [7:0]      w_ctrl [NREG];
  logic [7:0]      w_base [NREG];
  logic [NREG-1:0] w_match, w_first;
  logic [7:0]      w_t;
  logic            w_fc7;
  logic [WW-1:0]   w_wait;
  logic [WW-1:0]   r_wcnt;
  logic [RAW-1:0]  w_moff;
  logic            w_mhit;
  logic [7:0]      w_rd;
  logic [7:0]      r_dout;
  logic [AW:1]     w_maddr;
  logic [7:0]      w_dhi, w_dlo, w_ahi, w_amid, w_alo;

  assign w_t   = bus_addr[AW:AW-7];
  assign w_fc7 = (cpu_fc == 3'b111);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_region
      logic [7:0] r_ctrl, r_base;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_ctrl <= '0;
          r_base <= '0;
        end else if (reg_we) begin
          if (reg_addr == RAW'(2 * gi))     r_ctrl <= reg_din;
          if (reg_addr == RAW'(2 * gi + 1)) r_base <= reg_din;
        end
      end
      assign w_ctrl[gi]  = r_ctrl;
      assign w_base[gi]  = r_base;
      assign w_match[gi] = r_ctrl[2+WW] && (((w_t ^ r_base) & size_mask(r_ctrl[1:0])) == 8'h00);
    end
  endgenerate

  // Isolate the lowest set bit: index 0 has the highest priority.
  assign w_first = w_match & (~w_match + NREG'(1));
  assign active  = w_fc7 ? '0 : w_first;
  assign none    = (w_match == '0) && !w_fc7;

  // Wait code of the selected region; no match leaves it at 0.
  always_comb begin
    w_wait = '0;
    for (int r = 0; r < NREG; r++)
      if (w_first[r]) w_wait = w_ctrl[r][2+:WW];
  end

  // Counts cpu_cen pulses since the strobe fell, saturating at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          r_wcnt <= '0;
    else if (cpu_asn)                   r_wcnt <= '0;
    else if (cpu_cen && r_wcnt != '1)   r_wcnt <= r_wcnt + 1'b1;
  end

  always_comb begin
    cpu_dtackn = 1'b1;
    if (cpu_asn || bus_gnt || w_fc7) cpu_dtackn = 1'b1;
    else if (w_wait == '1)           cpu_dtackn = ~ext_ack;
    else                             cpu_dtackn = !(r_wcnt > w_wait);
  end

  assign w_moff = reg_addr - RAW'(M);
  assign w_mhit = (reg_addr >= RAW'(M)) && (w_moff < RAW'(7));

  jts16_mapgen_master #(
    .AW   (AW),
    .TOUT (TOUT)
  ) u_master (
    .clk     (clk),
    .rstn    (rstn),
    .i_we    (reg_we && w_mhit),
    .i_sel   (w_moff[2:0]),
    .i_din   (reg_din),
    .i_gnt   (bus_gnt),
    .i_rdata (bus_dout),
    .i_ack   (bus_ack),
    .o_req   (bus_req),
    .o_asn   (bus_asn),
    .o_rnw   (bus_rnw),
    .o_wdata (bus_din),
    .o_addr  (w_maddr),
    .o_dhi   (w_dhi),
    .o_dlo   (w_dlo),
    .o_ahi   (w_ahi),
    .o_amid  (w_amid),
    .o_alo   (w_alo),
    .o_busy  (busy),
    .o_err   (err)
  );

  assign bus_addr = bus_gnt ? w_maddr : addr;

  // Register read mux; the command register reads back as 0.
  always_comb begin
    w_rd = '0;
    for (int r = 0; r < NREG; r++) begin
      if (reg_addr == RAW'(2 * r))     w_rd = w_ctrl[r];
      if (reg_addr == RAW'(2 * r + 1)) w_rd = w_base[r];
    end
    if (w_mhit) begin
      case (w_moff[2:0])
        OFS_DHI:  w_rd = w_dhi;
        OFS_DLO:  w_rd = w_dlo;
        OFS_AHI:  w_rd = w_ahi;
        OFS_AMID: w_rd = w_amid;
        OFS_ALO:  w_rd = w_alo;
        OFS_STAT: w_rd = {5'd0, bus_gnt, err, busy};
        default:  w_rd = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_dout <= '0;
    else       r_dout <= w_rd;
  end

  assign reg_dout = r_dout;

endmodule

// File: tb/tb_jts16_mapgen.sv
module tb_jts16_mapgen;

  localparam int NREG = 8;
  localparam int AW   = 23;
  localparam int WW   = 2;
  localparam int TOUT = 255;
  localparam int RAW  = $clog2(2 * NREG + 8);
  localparam int M    = 2 * NREG;

  logic            clk = 1'b0;
  logic            rstn;
  logic            cpu_cen;
  logic [AW:1]     addr;
  logic            cpu_asn;
  logic [2:0]      cpu_fc;
  logic            ext_ack;
  logic            cpu_dtackn;
  logic [NREG-1:0] active;
  logic            none;
  logic            reg_we;
  logic [RAW-1:0]  reg_addr;
  logic [7:0]      reg_din;
  logic [7:0]      reg_dout;
  logic            bus_req;
  logic            bus_gnt;
  logic [AW:1]     bus_addr;
  logic            bus_asn;
  logic            bus_rnw;
  logic [15:0]     bus_din;
  logic [15:0]     bus_dout;
  logic            bus_ack;
  logic            busy;
  logic            err;

  jts16_mapgen #(
    .NREG (NREG),
    .AW   (AW),
    .WW   (WW),
    .TOUT (TOUT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cpu_cen    (cpu_cen),
    .addr       (addr),
    .cpu_asn    (cpu_asn),
    .cpu_fc     (cpu_fc),
    .ext_ack    (ext_ack),
    .cpu_dtackn (cpu_dtackn),
    .active     (active),
    .none       (none),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_din    (reg_din),
    .reg_dout   (reg_dout),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .bus_addr   (bus_addr),
    .bus_asn    (bus_asn),
    .bus_rnw    (bus_rnw),
    .bus_din    (bus_din),
    .bus_dout   (bus_dout),
    .bus_ack    (bus_ack),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Observable selectors for the scoreboard.
  localparam int S_ACTIVE = 0, S_NONE = 1, S_DTACK = 2, S_DOUT = 3, S_REQ = 4,
                 S_ASN = 5, S_RNW = 6, S_BUSY = 7, S_ERR = 8, S_BADDR = 9, S_BDIN = 10;

  typedef struct {
    int          id;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [31:0] get_act(input int id);
    case (id)
      S_ACTIVE: return 32'(active);
      S_NONE:   return 32'(none);
      S_DTACK:  return 32'(cpu_dtackn);
      S_DOUT:   return 32'(reg_dout);
      S_REQ:    return 32'(bus_req);
      S_ASN:    return 32'(bus_asn);
      S_RNW:    return 32'(bus_rnw);
      S_BUSY:   return 32'(busy);
      S_ERR:    return 32'(err);
      S_BADDR:  return 32'(bus_addr);
      S_BDIN:   return 32'(bus_din);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: outputs are stable at the falling edge; drain every pending expectation.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = get_act(e.id);
      n_total++;
      if (a === e.exp) begin
        n_pass++;
        $display("check %-14s got %0h expected %0h ok", e.name, a, e.exp);
      end else begin
        $display("FAIL %-14s got %0h expected %0h", e.name, a, e.exp);
      end
    end
  end

  task automatic chk(input int id, input logic [31:0] exp, input string name);
    exp_t e;
    e.id = id;
    e.exp = exp;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    reg_addr = RAW'(a);
    reg_din  = d;
    reg_we   = 1'b1;
    tick();
    reg_we   = 1'b0;
  endtask

  task automatic rd(input int a, input logic [7:0] exp, input string name);
    reg_addr = RAW'(a);
    tick();
    chk(S_DOUT, 32'(exp), name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; cpu_cen = 1'b0; addr = '0; cpu_asn = 1'b1; cpu_fc = 3'd5;
    ext_ack = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_din = '0;
    bus_gnt = 1'b0; bus_dout = '0; bus_ack = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Reset state
    chk(S_NONE, 1, "rst_none");
    chk(S_ACTIVE, 0, "rst_active");
    chk(S_DTACK, 1, "rst_dtackn");
    chk(S_REQ, 0, "rst_req");
    chk(S_ASN, 1, "rst_asn");
    chk(S_RNW, 1, "rst_rnw");
    chk(S_ERR, 0, "rst_err");
    chk(S_BUSY, 0, "rst_busy");
    chk(S_DOUT, 0, "rst_dout");
    tick();

    // Priority: region 0 (base 00, size 3) and region 1 (base 10, size 0)
    wr(0, 8'h13);
    wr(1, 8'h00);
    wr(2, 8'h10);
    wr(3, 8'h10);
    addr = 23'h080000;                 // byte address 0x100000
    chk(S_ACTIVE, 32'h01, "prio_r0");
    chk(S_NONE, 0, "prio_none");
    tick();
    wr(0, 8'h03);                      // disable region 0
    chk(S_ACTIVE, 32'h02, "prio_r1");
    rd(3, 8'h10, "rd_base1");
    rd(30, 8'h00, "rd_unmapped");
    addr = 23'h7F0000;                 // top byte 0xFE: no region
    chk(S_NONE, 1, "no_match");
    tick();

    // Region 2: base 0x20, wait code 2
    wr(4, 8'h18);
    wr(5, 8'h20);
    addr = 23'h100000;                 // byte address 0x200000
    chk(S_ACTIVE, 32'h04, "r2_active");
    cpu_asn = 1'b0;
    tick();
    chk(S_DTACK, 1, "wait_p0");
    for (int k = 1; k <= 3; k++) begin
      cpu_cen = 1'b1;
      tick();
      cpu_cen = 1'b0;
      chk(S_DTACK, (k >= 3) ? 32'd0 : 32'd1, $sformatf("wait_p%0d", k));
      tick();
    end
    cpu_asn = 1'b1;
    chk(S_DTACK, 1, "asn_high");
    tick();

    // Wait code 3: DTACK follows ext_ack
    wr(4, 8'h1C);
    cpu_asn = 1'b0;
    ext_ack = 1'b0;
    chk(S_DTACK, 1, "ext_ack0");
    tick();
    ext_ack = 1'b1;
    chk(S_DTACK, 0, "ext_ack1");
    tick();

    // Interrupt acknowledge cycle
    cpu_fc = 3'd7;
    chk(S_ACTIVE, 0, "fc7_active");
    chk(S_NONE, 0, "fc7_none");
    chk(S_DTACK, 1, "fc7_dtackn");
    tick();
    cpu_fc = 3'd5;
    cpu_asn = 1'b1;
    ext_ack = 1'b0;

    // Master read at 0x012345
    wr(M + 2, 8'h01);
    wr(M + 3, 8'h23);
    wr(M + 4, 8'h45);
    wr(M + 5, 8'h02);
    chk(S_REQ, 1, "rd_req");
    chk(S_BUSY, 1, "rd_busy");
    chk(S_ASN, 1, "rd_asn_req");
    tick();
    tick();
    bus_gnt = 1'b1;
    chk(S_BADDR, 32'h012345, "rd_busaddr");
    tick();
    chk(S_ASN, 0, "rd_asn_cyc");
    chk(S_RNW, 1, "rd_rnw");
    reg_addr = RAW'(M + 6);
    tick();
    chk(S_DOUT, 32'h05, "rd_status");
    bus_ack = 1'b1;
    bus_dout = 16'hBEEF;
    tick();
    bus_ack = 1'b0;
    bus_dout = 16'h0000;
    chk(S_BUSY, 1, "rd_busy_done");
    chk(S_ASN, 1, "rd_asn_done");
    chk(S_REQ, 0, "rd_req_done");
    tick();
    bus_gnt = 1'b0;
    chk(S_BUSY, 0, "rd_idle");
    chk(S_ERR, 0, "rd_err");
    rd(M, 8'hBE, "rd_dhi");
    rd(M + 1, 8'hEF, "rd_dlo");

    // Master write with withheld ack: timeout
    wr(M, 8'h12);
    wr(M + 1, 8'h34);
    wr(M + 5, 8'h01);
    chk(S_REQ, 1, "wr_req");
    chk(S_RNW, 0, "wr_rnw_req");
    bus_gnt = 1'b1;
    tick();
    chk(S_ASN, 0, "wr_asn_cyc");
    chk(S_BDIN, 32'h1234, "wr_bus_din");
    repeat (TOUT - 1) tick();
    chk(S_ASN, 0, "to_edge_asn");
    chk(S_ERR, 0, "to_edge_err");
    tick();
    chk(S_ERR, 1, "to_err");
    chk(S_REQ, 0, "to_req");
    chk(S_ASN, 1, "to_asn");
    tick();
    bus_gnt = 1'b0;
    chk(S_BUSY, 0, "to_idle");
    chk(S_ERR, 1, "to_err_sticky");
    tick();
    wr(M + 5, 8'h02);
    chk(S_ERR, 0, "err_clear");
    chk(S_REQ, 1, "req_again");

    // Command while busy, then reset during CYC
    bus_gnt = 1'b1;
    tick();
    chk(S_ASN, 0, "cyc2_asn");
    wr(M + 5, 8'h01);
    chk(S_RNW, 1, "busy_cmd_ign");
    chk(S_BUSY, 1, "busy_still");
    tick();
    rstn = 1'b0;
    chk(S_ASN, 1, "arst_asn");
    chk(S_REQ, 0, "arst_req");
    chk(S_BUSY, 0, "arst_busy");
    chk(S_DOUT, 0, "arst_dout");
    tick();
    bus_gnt = 1'b0;
    reg_addr = RAW'(4);
    rstn = 1'b1;
    tick();
    chk(S_NONE, 1, "post_none");
    chk(S_ACTIVE, 0, "post_active");
    chk(S_DTACK, 1, "post_dtackn");
    chk(S_ERR, 0, "post_err");
    chk(S_RNW, 1, "post_rnw");
    chk(S_REQ, 0, "post_req");
    chk(S_DOUT, 0, "post_dout");
    tick();
    tick();

    if (q.size() != 0) begin
      $display("FAIL scoreboard got %0d pending expected 0", q.size());
      n_total++;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jts16_mapgen.md
# jts16_mapgen

Parametrised successor of the S16B 315-5195 mapper. It decodes a 68000 address into up to `NREG` programmable regions, each with a base, size, enable bit and DTACK wait count. It also contains a bus-master engine that performs single 16-bit reads and writes on behalf of the register writer (MCU or CPU). It sits between the 68000 and the SDRAM/peripheral chip-selects, in the same position as the current mapper, and adds per-region enables, N-bit wait codes and a bus-cycle timeout with an error flag.

## Interface
Parameters:
- `NREG`, 8: number of regions, 1..16; index 0 has the highest priority.
- `AW`, 23: MSB of the word address; address bus is `[AW:1]`.
- `WW`, 2: wait-code width per region.
- `TOUT`, 255: master bus-cycle timeout, in clk cycles.

Ports (`RAW` = clog2(2·NREG+8)):
- `clk`  in  1  system clock
- `rstn`  in  1  asynchronous, active-low reset
- `cpu_cen`  in  1  68000 clock enable
- `addr`  in  AW  CPU address `[AW:1]`
- `cpu_asn`  in  1  CPU address strobe, active low
- `cpu_fc`  in  3  CPU function code
- `ext_ack`  in  1  external acknowledge, used by regions whose wait code is all-ones
- `cpu_dtackn`  out  1  DTACK to the CPU
- `active`  out  NREG  one-hot region select
- `none`  out  1  no region matches
- `reg_we`  in  1  register write strobe (one clk)
- `reg_addr`  in  RAW  register index
- `reg_din`  in  8  register write data
- `reg_dout`  out  8  register read data, registered
- `bus_req`  out  1  master bus request
- `bus_gnt`  in  1  bus grant
- `bus_addr`  out  AW  decoded address: master address while granted, otherwise `addr`
- `bus_asn`  out  1  master address strobe
- `bus_rnw`  out  1  master direction, 1 = read
- `bus_din`  out  16  master write data
- `bus_dout`  in  16  memory read data
- `bus_ack`  in  1  memory acknowledge
- `busy`  out  1  master engine is not idle
- `err`  out  1  sticky timeout flag

## Operation
**Register map**
- Register 2r, region r control: bit [1:0] size code, bits [2+:WW] wait code, bit [2+WW] enable.
- Register 2r+1: base byte for region r.
- Registers from `M` = 2·NREG upward: `M`+0 data hi, `M`+1 data lo, `M`+2..4 address hi/mid/lo (`[AW:1]`, right-aligned), `M`+5 command, `M`+6 status (read-only).
- Status register: bit0 busy, bit1 err, bit2 granted.
- Reads of unmapped indices return 0.

**Region decode** (combinational)
- `t` = `bus_addr[AW:AW-7]`.
- Size mask by size code: 0 → FF, 1 → FE, 2 → F8, 3 → E0.
- Region r matches when enabled and ((t ^ base) & mask) == 0.
- `active` is the lowest-index match only.
- `none` = enabled-match set is empty.
- When `cpu_fc` == 7, `active` = 0 and `none` = 0.

**DTACK**
- `cpu_dtackn` = 1 while `cpu_asn` is high or `bus_gnt` is high.
- Wait code w below all-ones: a counter starts when `cpu_asn` falls, counts `cpu_cen` pulses, and `cpu_dtackn` goes low after w+1 pulses. The counter saturates.
- Wait code all-ones: `cpu_dtackn` = ~`ext_ack`.
- When `none` is high, wait 0 applies.
- When `cpu_fc` == 7, `cpu_dtackn` stays 1 (interrupt acknowledge is handled elsewhere).

**Master FSM**: states IDLE, REQ, CYC, DONE.
- IDLE:
  - Command 01 (write) or 10 (read) → REQ, and `err` clears.
  - Commands 00 and 11 are ignored.
  - Command writes received outside IDLE are ignored.
- REQ: `bus_req` = 1. Moves to CYC on the first clk where `bus_gnt` = 1.
- CYC: `bus_asn` = 0, `bus_rnw` follows the command, `bus_din` = {data hi, data lo}.
  - `bus_ack` = 1 → DONE. On a read, data hi/lo load from `bus_dout` in the same edge.
  - `TOUT` cycles without `bus_ack` → `err` = 1, then DONE.
- DONE: `bus_asn` = 1, `bus_req` = 0, then IDLE.
- `busy` = state != IDLE.
- Register writes to data/address registers during CYC take effect immediately. Firmware must not issue them.

## Timing
- Reset values:
  - All registers are 0, so every region is disabled and `none` = 1.
  - FSM in IDLE.
  - `bus_req` = 0, `bus_asn` = 1, `bus_rnw` = 1, `err` = 0, `reg_dout` = 0, `cpu_dtackn` = 1.
- Reset asserted mid-cycle aborts the FSM to IDLE at once and drops `bus_asn` to 1 asynchronously.
- Register writes take effect on the clk edge where `reg_we` = 1. Decode reflects the new value on the next cycle.
- `reg_dout` has one clk of latency after `reg_addr`.
- Command to `bus_req`: 1 clk.
- `bus_gnt` to `bus_asn` low: 1 clk.
- `bus_ack` to `busy` low: 2 clk (CYC→DONE→IDLE).
- The timeout counter is `clog2(TOUT+1)` bits wide, clears on entry to CYC and must not wrap.

## Structure
- Package `jts16_mapgen_pkg`: FSM state constants, command codes (CMD_WR = 01, CMD_RD = 10), register offsets relative to `M`, size-mask function.
- Sub-module `jts16_mapgen_master`: FSM, timeout counter, data/address latches.
- Region decode and DTACK logic live in the top level.

## Test plan
- Region 0: base 0x00, size 3, enabled; region 1: base 0x10, size 0, enabled; `addr` byte 0x10_0000 → `active` = 0x01 (priority); disable region 0 → `active` = 0x02.
- Region 2: wait code 2, `addr` inside it, `cpu_asn` falls → `cpu_dtackn` low after exactly 3 `cpu_cen` pulses; set wait code 3 → `cpu_dtackn` tracks `ext_ack`.
- `cpu_fc` = 7 with a matching address → `active` = 0, `none` = 0, `cpu_dtackn` = 1.
- Read command at address 0x012345, `bus_gnt` 2 clk later, `bus_ack` with `bus_dout` = 0xBEEF → data regs = BE/EF, `busy` low 2 clk after ack, `err` = 0.
- Write command, `bus_gnt` given, `bus_ack` withheld → `err` = 1 after `TOUT` cycles in CYC, `bus_req` = 0; next command clears `err`.
- Command write while `busy`, and `rstn` pulsed low during CYC → second command ignored; after reset all outputs at reset values and `none` = 1.
